// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: sequencer states, opcode map, instruction classes and ALU operator mapping.
package cpu_ctrl_pkg;
  localparam int OPW = 5;
  localparam int REGSEL = 4;
  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  typedef enum logic [2:0] {K_NOP, K_ALU, K_UN, K_IMM, K_LD, K_ST, K_HALT} kind_t;
  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_NOT  = 5'b01000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b01001;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;
  typedef struct packed {
    logic PCout, Zlowout, MDRout, BAout, Cout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin;
    logic IncPC, Read, Write;
    logic Gra, Grb, Grc, Rin, Rout;
    logic [OPW-1:0] Operator;
  } ctrl_t;
  function automatic kind_t kind_of(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return K_ALU;
      OP_NOT, OP_NEG:                return K_UN;
      OP_ADDI, OP_ANDI:              return K_IMM;
      OP_LD:                         return K_LD;
      OP_ST:                         return K_ST;
      OP_HALT:                       return K_HALT;
      default:                       return K_NOP;
    endcase
  endfunction
  // Address arithmetic for LD/ST and immediates reuses the ALU add/and codes.
  function automatic logic [OPW-1:0] alu_op(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return op;
      OP_NOT:                        return 5'b10001;
      OP_NEG:                        return 5'b10000;
      OP_ADDI, OP_LD, OP_ST:         return OP_ADD;
      OP_ANDI:                       return OP_AND;
      default:                       return '0;
    endcase
  endfunction
endpackage

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM issuing fetch/execute strobes to the DataPath.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           clear,
  input  logic [31:0]    ir,
  input  logic           mem_rdy,
  output logic           PCout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           BAout,
  output logic           Cout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] Operator,
  output logic           Run
);
  state_t state, nxt;
  kind_t k;
  ctrl_t c, g;
  logic [OPW-1:0] aop;
  logic unused_ir;
  assign unused_ir = ^ir[26:0];
  assign k = kind_of(ir[31:27]);
  assign aop = alu_op(ir[31:27]);
  always_ff @(posedge clk or negedge clear)
    if (!clear) state <= T0;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      T0: nxt = T1;
      T1: nxt = mem_rdy ? T2 : T1;
      T2: nxt = T3;
      T3: nxt = (k == K_HALT) ? HALT : (k == K_NOP) ? T0 : T4;
      T4: nxt = (k == K_UN) ? T0 : T5;
      T5: nxt = (k == K_LD || k == K_ST) ? T6 : T0;
      T6: nxt = (k == K_LD && !mem_rdy) ? T6 : T7;
      T7: nxt = (k == K_ST && !mem_rdy) ? T7 : T0;
      default: nxt = state;
    endcase
  end
  always_comb begin
    c = '0;
    case (state)
      T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; end
      T1: begin c.Zlowout = 1'b1; c.PCin = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1; end
      T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      T3: begin
        c.Grb = k inside {K_ALU, K_UN, K_IMM, K_LD, K_ST};
        c.Rout = k inside {K_ALU, K_UN, K_IMM};
        c.BAout = k inside {K_LD, K_ST};
        c.Yin = k inside {K_ALU, K_IMM, K_LD, K_ST};
        c.Zin = (k == K_UN);
        c.Operator = (k == K_UN) ? aop : '0;
      end
      T4: begin
        c.Grc = (k == K_ALU);
        c.Rout = (k == K_ALU);
        c.Cout = k inside {K_IMM, K_LD, K_ST};
        c.Zin = (k != K_UN);
        c.Operator = (k == K_UN) ? '0 : aop;
        c.Zlowout = (k == K_UN);
        c.Gra = (k == K_UN);
        c.Rin = (k == K_UN);
      end
      T5: begin
        c.Zlowout = 1'b1;
        c.MARin = k inside {K_LD, K_ST};
        c.Gra = !(k inside {K_LD, K_ST});
        c.Rin = !(k inside {K_LD, K_ST});
      end
      T6: begin
        c.Read = (k == K_LD);
        c.MDRin = 1'b1;
        c.Gra = (k == K_ST);
        c.Rout = (k == K_ST);
      end
      T7: begin
        c.Write = (k == K_ST);
        c.MDRout = (k == K_LD);
        c.Gra = (k == K_LD);
        c.Rin = (k == K_LD);
      end
      default: c = '0;
    endcase
  end
  // Strobes are forced low for as long as clear is held, independent of the clock.
  assign g = clear ? c : '0;
  assign {PCout, Zlowout, MDRout, BAout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin,
          IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, Operator} = g;
  assign Run = (state != HALT);
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-cycle scoreboard of strobe vectors from an instruction-recipe model.
module tb_control_sequencer;
  logic clk = 1'b0, clear = 1'b0, mem_rdy = 1'b1;
  logic [31:0] ir = '0;
  logic PCout, Zlowout, MDRout, BAout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, Run;
  logic [4:0] Operator;
  logic [24:0] obs;
  int errors = 0, checks = 0;
  logic [24:0] q_exp[$];
  logic [31:0] q_ir[$];

  localparam logic [24:0] PCO = 25'd1 << 24, ZLO = 25'd1 << 23, MDRO = 25'd1 << 22;
  localparam logic [24:0] BAO = 25'd1 << 21, CO = 25'd1 << 20, MARI = 25'd1 << 19;
  localparam logic [24:0] ZI = 25'd1 << 18, PCI = 25'd1 << 17, MDRI = 25'd1 << 16;
  localparam logic [24:0] IRI = 25'd1 << 15, YI = 25'd1 << 14, INC = 25'd1 << 13;
  localparam logic [24:0] RD = 25'd1 << 12, WR = 25'd1 << 11, GA = 25'd1 << 10;
  localparam logic [24:0] GB = 25'd1 << 9, GC = 25'd1 << 8, RI = 25'd1 << 7;
  localparam logic [24:0] RO = 25'd1 << 6, RUN = 25'd1;

  control_sequencer dut (
    .clk(clk), .clear(clear), .ir(ir), .mem_rdy(mem_rdy),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .Operator(Operator), .Run(Run)
  );

  assign obs = {PCout, Zlowout, MDRout, BAout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin,
                IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, Operator, Run};

  always #5 clk = ~clk;

  always @(negedge clk)
    if (q_exp.size() > 0) begin
      logic [24:0] e;
      logic [31:0] i;
      e = q_exp.pop_front();
      i = q_ir.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL strobes ir=%h clear=%b got=%h expected=%h", i, clear, obs, e);
      end
    end

  task automatic cycle(input logic clr, input logic rdy, input logic [31:0] i, input logic [24:0] e);
    @(posedge clk);
    #1;
    clear = clr;
    mem_rdy = rdy;
    ir = i;
    q_exp.push_back(e);
    q_ir.push_back(i);
  endtask

  task automatic wait_step(input int w, input logic [31:0] i, input logic [24:0] e);
    for (int n = 0; n < w; n++) cycle(1'b1, 1'b0, i, e);
    cycle(1'b1, 1'b1, i, e);
  endtask

  task automatic run_instr(input logic [31:0] i, input int w1, input int w2, input bit abort);
    logic [4:0] op;
    logic [24:0] opf;
    bit alu, un, imm, ld, st, hlt;
    op = i[31:27];
    alu = op inside {5'd3, 5'd4, 5'd5, 5'd6};
    un = op inside {5'd8, 5'd9};
    imm = op inside {5'd12, 5'd13};
    ld = (op == 5'd0);
    st = (op == 5'd2);
    hlt = (op == 5'd27);
    opf = '0;
    if (alu) opf[5:1] = op;
    if (op == 5'd8) opf[5:1] = 5'd17;
    if (op == 5'd9) opf[5:1] = 5'd16;
    if (op == 5'd12 || ld || st) opf[5:1] = 5'd3;
    if (op == 5'd13) opf[5:1] = 5'd5;
    cycle(1'b1, 1'($urandom), i, RUN | PCO | MARI | INC | ZI);
    wait_step(w1, i, RUN | ZLO | PCI | RD | MDRI);
    cycle(1'b1, 1'($urandom), i, RUN | MDRO | IRI);
    if (alu || imm) cycle(1'b1, 1'($urandom), i, RUN | GB | RO | YI);
    else if (un) cycle(1'b1, 1'($urandom), i, RUN | GB | RO | ZI | opf);
    else if (ld || st) cycle(1'b1, 1'($urandom), i, RUN | GB | BAO | YI);
    else cycle(1'b1, 1'($urandom), i, RUN);
    if (hlt) begin
      for (int n = 0; n < 20; n++) cycle(1'b1, 1'($urandom), i, '0);
      cycle(1'b0, 1'($urandom), i, RUN);
    end
    if (alu) cycle(1'b1, 1'($urandom), i, RUN | GC | RO | ZI | opf);
    if (un) cycle(1'b1, 1'($urandom), i, RUN | ZLO | GA | RI);
    if (imm || ld || st) cycle(1'b1, 1'($urandom), i, RUN | CO | ZI | opf);
    if (alu || imm) cycle(1'b1, 1'($urandom), i, RUN | ZLO | GA | RI);
    if (ld || st) cycle(1'b1, 1'($urandom), i, RUN | ZLO | MARI);
    if (ld) begin
      wait_step(w2, i, RUN | RD | MDRI);
      cycle(1'b1, 1'($urandom), i, RUN | MDRO | GA | RI);
    end
    if (st) begin
      cycle(1'b1, 1'($urandom), i, RUN | GA | RO | MDRI);
      if (abort) begin
        for (int n = 0; n < w2; n++) cycle(1'b1, 1'b0, i, RUN | WR);
        cycle(1'b0, 1'b0, i, RUN);
      end else wait_step(w2, i, RUN | WR);
    end
  endtask

  initial begin
    logic [4:0] ops [12];
    logic [31:0] i;
    ops = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd12, 5'd13, 5'd27, 5'd31};
    cycle(1'b0, 1'b1, 32'h0, RUN);
    cycle(1'b0, 1'b1, 32'h0, RUN);
    run_instr(32'h42900000, 0, 0, 1'b0);
    run_instr(32'h18918000, 0, 0, 1'b0);
    run_instr(32'h00800065, 3, 3, 1'b0);
    run_instr(32'h10800065, 1, 3, 1'b1);
    run_instr(32'hD8000000, 0, 0, 1'b0);
    run_instr(32'hF8000000, 0, 0, 1'b0);
    run_instr(32'h10800065, 2, 2, 1'b0);
    for (int n = 0; n < 60; n++) begin
      i = $urandom;
      i[31:27] = ops[$urandom_range(0, 11)];
      if (n % 7 == 6) i[31:27] = 5'($urandom);
      run_instr(i, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending required=0", q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
